mem_addr_router: RTL and testbench

Address-decoding router between the processor-side memory network port and two memory servers: main memory and the peripheral memory server (STDOUT at 0xF0000000, STDIN at 0xF0000004). Each request goes to exactly one target, chosen by address. Responses return to the processor strictly in request order, tracked by a small in-order destination FIFO. The router adds zero request latency and zero response latency, only combinational steering. Its one piece of state is the ordering tracker, which bounds outstanding requests.

---
 rtl/mem_addr_router.sv | 126 ++++++++++++
 tb/tb_mem_addr_router.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_router.sv
// Steers processor requests to main memory or the peripheral server by address.
// Responses return in request order via a 1-bit destination FIFO.
module mem_addr_router #(
   parameter int          p_payload_bits = 78,
   parameter int          p_resp_bits    = 78,
   parameter logic [31:0] p_periph_base  = 32'hF0000000,
   parameter logic [31:0] p_periph_mask  = 32'hF0000000,
   parameter int          p_max_inflight = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_val,
   output logic                      req_rdy,
   input  logic [31:0]               req_addr,
   input  logic [p_payload_bits-1:0] req_payload,
   output logic                      mem_req_val,
   input  logic                      mem_req_rdy,
   output logic [31:0]               mem_req_addr,
   output logic [p_payload_bits-1:0] mem_req_payload,
   output logic                      per_req_val,
   input  logic                      per_req_rdy,
   output logic [31:0]               per_req_addr,
   output logic [p_payload_bits-1:0] per_req_payload,
   input  logic                      mem_resp_val,
   output logic                      mem_resp_rdy,
   input  logic [p_resp_bits-1:0]    mem_resp_msg,
   input  logic                      per_resp_val,
   output logic                      per_resp_rdy,
   input  logic [p_resp_bits-1:0]    per_resp_msg,
   output logic                      resp_val,
   input  logic                      resp_rdy,
   output logic [p_resp_bits-1:0]    resp_msg,
   output logic [$clog2(p_max_inflight+1)-1:0] inflight
);

   localparam int CW = $clog2(p_max_inflight + 1);
   localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(p_max_inflight);
   localparam logic [PW-1:0] LAST_PTR = PW'(p_max_inflight - 1);

   logic [p_max_inflight-1:0] dst_q, dst_d;
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             cnt_q, cnt_d;

   logic is_per;
   logic full;
   logic empty;
   logic head;
   logic req_fire;
   logic resp_fire;

   assign is_per    = ((req_addr & p_periph_mask) == p_periph_base);
   assign full      = (cnt_q == MAX_CNT);
   assign empty     = (cnt_q == '0);
   assign head      = dst_q[rd_ptr_q];
   assign req_fire  = req_val & req_rdy;
   assign resp_fire = resp_val & resp_rdy;
   assign inflight  = cnt_q;

   // Request steering: fan address/payload out, qualify val by target and space
   always_comb begin
      mem_req_addr    = req_addr;
      mem_req_payload = req_payload;
      per_req_addr    = req_addr;
      per_req_payload = req_payload;
      mem_req_val     = req_val & ~is_per & ~full;
      per_req_val     = req_val & is_per & ~full;
      req_rdy         = ~full & (is_per ? per_req_rdy : mem_req_rdy);
   end

   // Response steering: only the source recorded at the FIFO head may pass
   always_comb begin
      resp_val     = 1'b0;
      resp_msg     = mem_resp_msg;
      mem_resp_rdy = 1'b0;
      per_resp_rdy = 1'b0;
      if (!empty) begin
         if (head) begin
            resp_val     = per_resp_val;
            resp_msg     = per_resp_msg;
            per_resp_rdy = resp_rdy;
         end else begin
            resp_val     = mem_resp_val;
            resp_msg     = mem_resp_msg;
            mem_resp_rdy = resp_rdy;
         end
      end
   end

   // Ordering tracker next state: push on request fire, pop on response fire
   always_comb begin
      dst_d    = dst_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (req_fire) begin
         dst_d[wr_ptr_q] = is_per;
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (resp_fire) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({req_fire, resp_fire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Tracker state registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         dst_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         dst_q    <= dst_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_addr_router.sv
// Bench for mem_addr_router: directed scenarios then a randomized
// run checked against a queue-based ordering model.
module tb_mem_addr_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_val, req_rdy;
   logic [31:0] req_addr;
   logic [77:0] req_payload;
   logic        mem_req_val, mem_req_rdy;
   logic [31:0] mem_req_addr;
   logic [77:0] mem_req_payload;
   logic        per_req_val, per_req_rdy;
   logic [31:0] per_req_addr;
   logic [77:0] per_req_payload;
   logic        mem_resp_val, mem_resp_rdy;
   logic [77:0] mem_resp_msg;
   logic        per_resp_val, per_resp_rdy;
   logic [77:0] per_resp_msg;
   logic        resp_val, resp_rdy;
   logic [77:0] resp_msg;
   logic [2:0]  inflight;

   int n_asrt = 0;
   int n_fail = 0;

   typedef struct {
      logic        per;
      logic [77:0] msg;
   } exp_t;

   exp_t        exp_q[$];
   logic [77:0] mem_q[$];
   logic [77:0] per_q[$];

   mem_addr_router dut (
      .clk             (clk),
      .rst             (rst),
      .req_val         (req_val),
      .req_rdy         (req_rdy),
      .req_addr        (req_addr),
      .req_payload     (req_payload),
      .mem_req_val     (mem_req_val),
      .mem_req_rdy     (mem_req_rdy),
      .mem_req_addr    (mem_req_addr),
      .mem_req_payload (mem_req_payload),
      .per_req_val     (per_req_val),
      .per_req_rdy     (per_req_rdy),
      .per_req_addr    (per_req_addr),
      .per_req_payload (per_req_payload),
      .mem_resp_val    (mem_resp_val),
      .mem_resp_rdy    (mem_resp_rdy),
      .mem_resp_msg    (mem_resp_msg),
      .per_resp_val    (per_resp_val),
      .per_resp_rdy    (per_resp_rdy),
      .per_resp_msg    (per_resp_msg),
      .resp_val        (resp_val),
      .resp_rdy        (resp_rdy),
      .resp_msg        (resp_msg),
      .inflight        (inflight)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_val      = 1'b0;
      req_addr     = 32'h0;
      req_payload  = '0;
      mem_req_rdy  = 1'b0;
      per_req_rdy  = 1'b0;
      mem_resp_val = 1'b0;
      mem_resp_msg = '0;
      per_resp_val = 1'b0;
      per_resp_msg = '0;
      resp_rdy     = 1'b0;
   endtask

   initial begin
      logic        rv, want_per, full_m, exp_rdy, exp_rv, tgt_rdy;
      logic [31:0] a;
      logic [77:0] m;
      int          issued;
      int          ncyc;
      int          peak;

      rst = 1'b1;
      idle();
      cyc();
      cyc();
      // reset state, with a stray response presented
      mem_resp_val = 1'b1;
      per_resp_val = 1'b1;
      resp_rdy     = 1'b1;
      #1;
      chk("rst_inflight", 128'(inflight), 128'(0));
      chk("rst_resp_val", 128'(resp_val), 128'(0));
      chk("rst_mem_rrdy", 128'(mem_resp_rdy), 128'(0));
      chk("rst_per_rrdy", 128'(per_resp_rdy), 128'(0));
      rst = 1'b0;
      cyc();
      idle();

      // single read to main memory
      req_val     = 1'b1;
      req_addr    = 32'h0000_1000;
      req_payload = 78'h123;
      mem_req_rdy = 1'b1;
      #1;
      chk("rd_mem_val", 128'(mem_req_val), 128'(1));
      chk("rd_per_val", 128'(per_req_val), 128'(0));
      chk("rd_req_rdy", 128'(req_rdy), 128'(1));
      chk("rd_addr", 128'(mem_req_addr), 128'(32'h0000_1000));
      cyc();
      idle();
      mem_resp_val = 1'b1;
      mem_resp_msg = 78'hABCDE;
      resp_rdy     = 1'b1;
      #1;
      chk("rd_inflight1", 128'(inflight), 128'(1));
      chk("rd_resp_val", 128'(resp_val), 128'(1));
      chk("rd_resp_msg", 128'(resp_msg), 128'(78'hABCDE));
      chk("rd_mem_rrdy", 128'(mem_resp_rdy), 128'(1));
      cyc();
      idle();
      #1;
      chk("rd_inflight0", 128'(inflight), 128'(0));

      // write to STDOUT
      req_val     = 1'b1;
      req_addr    = 32'hF000_0000;
      req_payload = 78'h1_0000_0000_0000_0041;
      per_req_rdy = 1'b1;
      #1;
      chk("wr_per_val", 128'(per_req_val), 128'(1));
      chk("wr_mem_val", 128'(mem_req_val), 128'(0));
      chk("wr_payload", 128'(per_req_payload),
          128'(78'h1_0000_0000_0000_0041));
      cyc();
      idle();
      per_resp_val = 1'b1;
      per_resp_msg = 78'h77;
      resp_rdy     = 1'b1;
      #1;
      chk("wr_resp_val", 128'(resp_val), 128'(1));
      chk("wr_resp_msg", 128'(resp_msg), 128'(78'h77));
      chk("wr_per_rrdy", 128'(per_resp_rdy), 128'(1));
      cyc();
      idle();

      // ordering: mem A then peripheral B, B answers first
      req_val     = 1'b1;
      req_addr    = 32'h0000_2000;
      mem_req_rdy = 1'b1;
      cyc();
      req_addr    = 32'hF000_0004;
      mem_req_rdy = 1'b0;
      per_req_rdy = 1'b1;
      #1;
      chk("ord_b_rdy", 128'(req_rdy), 128'(1));
      cyc();
      idle();
      per_resp_val = 1'b1;
      per_resp_msg = 78'hB;
      resp_rdy     = 1'b1;
      #1;
      chk("ord_infl2", 128'(inflight), 128'(2));
      chk("ord_stall_rdy", 128'(per_resp_rdy), 128'(0));
      chk("ord_stall_val", 128'(resp_val), 128'(0));
      cyc();
      mem_resp_val = 1'b1;
      mem_resp_msg = 78'hA;
      #1;
      chk("ord_a_val", 128'(resp_val), 128'(1));
      chk("ord_a_msg", 128'(resp_msg), 128'(78'hA));
      chk("ord_a_prdy", 128'(per_resp_rdy), 128'(0));
      cyc();
      mem_resp_val = 1'b0;
      #1;
      chk("ord_b_val", 128'(resp_val), 128'(1));
      chk("ord_b_msg", 128'(resp_msg), 128'(78'hB));
      chk("ord_b_prdy", 128'(per_resp_rdy), 128'(1));
      cyc();
      idle();
      #1;
      chk("ord_infl0", 128'(inflight), 128'(0));

      // full tracker
      req_val     = 1'b1;
      req_addr    = 32'h0000_3000;
      mem_req_rdy = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      mem_resp_val = 1'b1;
      mem_resp_msg = 78'h5;
      resp_rdy     = 1'b1;
      #1;
      chk("full_infl4", 128'(inflight), 128'(4));
      chk("full_req_rdy", 128'(req_rdy), 128'(0));
      chk("full_mem_val", 128'(mem_req_val), 128'(0));
      chk("full_resp", 128'(resp_val), 128'(1));
      cyc();
      mem_resp_val = 1'b0;
      #1;
      chk("full_infl3", 128'(inflight), 128'(3));
      chk("full_5th_rdy", 128'(req_rdy), 128'(1));
      cyc();
      req_val = 1'b0;
      #1;
      chk("full_infl4b", 128'(inflight), 128'(4));
      mem_resp_val = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      idle();
      #1;
      chk("full_drain", 128'(inflight), 128'(0));

      // randomized traffic against an in-order model
      issued = 0;
      ncyc   = 0;
      peak   = 0;
      while ((issued < 100 || exp_q.size() != 0) && ncyc < 4000) begin
         ncyc++;
         rv       = (issued < 100) && ($urandom_range(0, 3) != 0);
         want_per = 1'(issued) ^ ($urandom_range(0, 4) == 0);
         a        = $urandom;
         if (want_per) a[31:28] = 4'hF;
         else if (a[31:28] == 4'hF) a[31:28] = 4'h7;
         req_val      = rv;
         req_addr     = a;
         req_payload  = {14'($urandom), $urandom, $urandom};
         mem_req_rdy  = ($urandom_range(0, 3) != 0);
         per_req_rdy  = ($urandom_range(0, 3) != 0);
         mem_resp_val = (mem_q.size() != 0) && ($urandom_range(0, 2) != 0);
         mem_resp_msg = (mem_q.size() != 0) ? mem_q[0]
                      : {14'($urandom), $urandom, $urandom};
         per_resp_val = (per_q.size() != 0) && ($urandom_range(0, 2) != 0);
         per_resp_msg = (per_q.size() != 0) ? per_q[0]
                      : {14'($urandom), $urandom, $urandom};
         resp_rdy     = ($urandom_range(0, 3) != 0);
         #1;
         full_m  = (exp_q.size() == 4);
         tgt_rdy = want_per ? per_req_rdy : mem_req_rdy;
         exp_rdy = !full_m && tgt_rdy;
         exp_rv  = 1'b0;
         if (exp_q.size() != 0)
            exp_rv = exp_q[0].per ? per_resp_val : mem_resp_val;
         if (exp_q.size() > peak) peak = exp_q.size();
         chk("rnd_req_rdy", 128'(req_rdy), 128'(exp_rdy));
         chk("rnd_mem_val", 128'(mem_req_val),
             128'(rv && !want_per && !full_m));
         chk("rnd_per_val", 128'(per_req_val),
             128'(rv && want_per && !full_m));
         chk("rnd_inflight", 128'(inflight), 128'(exp_q.size()));
         chk("rnd_resp_val", 128'(resp_val), 128'(exp_rv));
         if (exp_rv) begin
            chk("rnd_resp_msg", 128'(resp_msg), 128'(exp_q[0].msg));
            chk("rnd_mem_rrdy", 128'(mem_resp_rdy),
                128'(!exp_q[0].per && resp_rdy));
            chk("rnd_per_rrdy", 128'(per_resp_rdy),
                128'(exp_q[0].per && resp_rdy));
         end
         if (exp_rv && resp_rdy) begin
            if (exp_q[0].per) void'(per_q.pop_front());
            else void'(mem_q.pop_front());
            void'(exp_q.pop_front());
         end
         if (rv && exp_rdy) begin
            m = {14'($urandom), $urandom, $urandom};
            exp_q.push_back('{per: want_per, msg: m});
            if (want_per) per_q.push_back(m);
            else mem_q.push_back(m);
            issued++;
         end
         cyc();
      end
      chk("rnd_done", 128'(ncyc < 4000), 128'(1));
      chk("rnd_peak_le4", 128'(peak <= 4), 128'(1));
      idle();

      // reset with 3 outstanding
      req_val     = 1'b1;
      req_addr    = 32'h0000_4000;
      mem_req_rdy = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      req_val = 1'b0;
      #1;
      chk("rst3_infl3", 128'(inflight), 128'(3));
      rst = 1'b1;
      cyc();
      rst          = 1'b0;
      per_resp_val = 1'b1;
      resp_rdy     = 1'b1;
      #1;
      chk("rst3_infl0", 128'(inflight), 128'(0));
      chk("rst3_resp_val", 128'(resp_val), 128'(0));
      chk("rst3_per_rrdy", 128'(per_resp_rdy), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
